// File: rtl/receiver_arb_pkg.sv
// Shared definitions for the receiver UART arbiter: FSM state encoding,
// channel/word geometry and the 4-byte tagged frame builder.
package receiver_arb_pkg;

   localparam int   NUM_CH      = 3;
   localparam int   WORD_W      = 17;
   localparam int   FRAME_BYTES = 4;
   localparam logic HDR_MARK    = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_START,
      ST_ACK,
      ST_DONE,
      ST_GAP
   } state_e;

   // frame[0] goes out first
   typedef logic [FRAME_BYTES-1:0][7:0] frame_t;

   // Header carries the marker bit, the channel tag and the word MSB;
   // the last byte is an XOR check over the first three.
   function automatic frame_t build_frame(input logic [1:0] ch,
                                          input logic [WORD_W-1:0] w);
      frame_t f;
      f[0] = {HDR_MARK, ch, 4'b0000, w[16]};
      f[1] = w[15:8];
      f[2] = w[7:0];
      f[3] = f[0] ^ f[1] ^ f[2];
      return f;
   endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Combinational 3-way round-robin select. Searches req starting one past
// the last granted channel (wrapping 2 -> 0) and returns the first hit.
//   req[2:0]      requesting channels
//   last[1:0]     previously granted channel
//   gnt[2:0]      one-hot grant
//   gnt_idx[1:0]  granted channel index
//   any           at least one request present
module rr_arbiter3 (
   input  logic [2:0] req,
   input  logic [1:0] last,
   output logic [2:0] gnt,
   output logic [1:0] gnt_idx,
   output logic       any
);

   logic [1:0] cand;
   logic       found;

   assign any = |req;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      cand    = (last == 2'd0) ? 2'd1 : (last == 2'd1) ? 2'd2 : 2'd0;
      for (int i = 0; i < 3; i++) begin
         if (!found && req[cand]) begin
            found      = 1'b1;
            gnt_idx    = cand;
            gnt[cand]  = 1'b1;
         end
         cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
      end
   end

endmodule

// File: rtl/receiver_uart_arbiter.sv
// Shares one byte-wide UART TX between three receiver channels. Each channel
// has a one-word holding buffer; a round-robin grant moves a word into the
// frame register, which is then sent as four tagged bytes over the
// tx_start/tx_ready handshake, followed by an optional idle gap.
//   clk_25MHz, rst_n     clock, async active-low reset
//   ch_valid/ch_ready    per-channel word handshake (ready = buffer empty)
//   ch_data              channel k word at [17k+16:17k]
//   tx_data/tx_start     byte and one-cycle start pulse to the UART
//   tx_ready             UART idle
//   busy                 FSM not idle
module receiver_uart_arbiter
   import receiver_arb_pkg::*;
#(
   parameter int GAP_CYCLES = 16
) (
   input  logic                     clk_25MHz,
   input  logic                     rst_n,
   input  logic [NUM_CH-1:0]        ch_valid,
   input  logic [NUM_CH*WORD_W-1:0] ch_data,
   output logic [NUM_CH-1:0]        ch_ready,
   output logic [7:0]               tx_data,
   output logic                     tx_start,
   input  logic                     tx_ready,
   output logic                     busy
);

   localparam int            GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [1:0]    IDX_LAST = 2'(FRAME_BYTES - 1);

   state_e                         state_q, state_d;
   logic [NUM_CH-1:0]              full_q, full_d;
   logic [NUM_CH-1:0][WORD_W-1:0]  buf_q, buf_d;
   logic [1:0]                     last_q, last_d;
   logic [1:0]                     idx_q, idx_d;
   logic [GW-1:0]                  gap_q, gap_d;
   frame_t                         frame_q, frame_d;
   logic [7:0]                     tx_data_q, tx_data_d;

   logic [2:0]        gnt;
   logic [1:0]        gnt_idx;
   logic              gnt_any;
   logic [WORD_W-1:0] sel_word;

   rr_arbiter3 u_rr (
      .req     (full_q),
      .last    (last_q),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .any     (gnt_any)
   );

   always_comb begin
      sel_word = '0;
      for (int k = 0; k < NUM_CH; k++)
         if (gnt[k]) sel_word = buf_q[k];
   end

   assign ch_ready = ~full_q;
   assign tx_data  = tx_data_q;
   assign tx_start = (state_q == ST_START);
   assign busy     = (state_q != ST_IDLE);

   always_comb begin
      state_d   = state_q;
      full_d    = full_q;
      buf_d     = buf_q;
      last_d    = last_q;
      idx_d     = idx_q;
      gap_d     = gap_q;
      frame_d   = frame_q;
      tx_data_d = tx_data_q;

      // Capture only into empty buffers; the arbiter below scans full_q, so a
      // word captured this cycle competes on the next scan.
      for (int k = 0; k < NUM_CH; k++) begin
         if (ch_valid[k] && !full_q[k]) begin
            full_d[k] = 1'b1;
            buf_d[k]  = ch_data[k*WORD_W +: WORD_W];
         end
      end

      unique case (state_q)
         ST_IDLE: begin
            if (gnt_any) begin
               last_d          = gnt_idx;
               frame_d         = build_frame(gnt_idx, sel_word);
               full_d          = full_d & ~gnt;
               tx_data_d       = frame_d[0];
               idx_d           = 2'd0;
               state_d         = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (tx_ready) state_d = ST_START;
         end
         ST_START: begin
            state_d = ST_ACK;
         end
         ST_ACK: begin
            if (!tx_ready) state_d = ST_DONE;
         end
         ST_DONE: begin
            if (tx_ready) begin
               if (idx_q != IDX_LAST) begin
                  idx_d     = idx_q + 2'd1;
                  tx_data_d = frame_q[idx_q + 2'd1];
                  state_d   = ST_LOAD;
               end else if (GAP_CYCLES == 0) begin
                  state_d = ST_IDLE;
               end else begin
                  gap_d   = '0;
                  state_d = ST_GAP;
               end
            end
         end
         ST_GAP: begin
            if (gap_q == GAP_LAST) state_d = ST_IDLE;
            else                   gap_d   = gap_q + 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_25MHz or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         full_q    <= '0;
         buf_q     <= '0;
         last_q    <= 2'd2;
         idx_q     <= 2'd0;
         gap_q     <= '0;
         frame_q   <= '0;
         tx_data_q <= 8'h00;
      end else begin
         state_q   <= state_d;
         full_q    <= full_d;
         buf_q     <= buf_d;
         last_q    <= last_d;
         idx_q     <= idx_d;
         gap_q     <= gap_d;
         frame_q   <= frame_d;
         tx_data_q <= tx_data_d;
      end
   end

endmodule

// File: tb/tb_receiver_uart_arbiter.sv
// Scoreboard bench for receiver_uart_arbiter: directed stimulus pushes the
// hand-computed byte stream into exp_q; a monitor pops and compares on every
// tx_start. A small UART model acknowledges each byte after 10 cycles.
module tb_receiver_uart_arbiter;

   logic        clk_25MHz = 1'b0;
   logic        rst_n     = 1'b0;
   logic [2:0]  ch_valid  = '0;
   logic [50:0] ch_data   = '0;
   logic [2:0]  ch_ready;
   logic [7:0]  tx_data;
   logic        tx_start;
   logic        tx_ready  = 1'b1;
   logic        busy;

   int         n_cmp = 0;
   int         n_bad = 0;
   int         start_cnt = 0;
   logic       prev_start = 1'b0;
   logic [7:0] exp_q[$];
   bit         stall_next = 1'b0;
   bit         stall_active = 1'b0;

   receiver_uart_arbiter #(.GAP_CYCLES(16)) dut (
      .clk_25MHz (clk_25MHz),
      .rst_n     (rst_n),
      .ch_valid  (ch_valid),
      .ch_data   (ch_data),
      .ch_ready  (ch_ready),
      .tx_data   (tx_data),
      .tx_start  (tx_start),
      .tx_ready  (tx_ready),
      .busy      (busy)
   );

   always #20 clk_25MHz = ~clk_25MHz;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // monitor / scoreboard
   always @(negedge clk_25MHz) begin : mon
      logic [7:0] e;
      if (rst_n && tx_start) begin
         start_cnt++;
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL tx_byte: got %02h expected none", tx_data);
         end else begin
            e = exp_q.pop_front();
            if (tx_data !== e) begin
               n_bad++;
               $display("FAIL tx_byte: got %02h expected %02h", tx_data, e);
            end
         end
         n_cmp++;
         if (prev_start) begin
            n_bad++;
            $display("FAIL start_width: got 2+ cycles expected 1");
         end
      end
      prev_start = tx_start;
   end

   // UART model: busy for 10 cycles per byte; optional 200-cycle stall
   // that catches the arbiter in LOAD of the next byte.
   initial begin
      forever begin
         @(negedge clk_25MHz);
         if (rst_n && tx_start) begin
            @(posedge clk_25MHz); #1 tx_ready = 1'b0;
            repeat (10) @(posedge clk_25MHz);
            #1 tx_ready = 1'b1;
            if (stall_next) begin
               stall_next = 1'b0;
               @(posedge clk_25MHz); #1 tx_ready = 1'b0;
               stall_active = 1'b1;
               repeat (200) @(posedge clk_25MHz);
               #1 tx_ready = 1'b1;
               stall_active = 1'b0;
            end
         end
      end
   end

   initial begin
      #3ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic set_ch(input int k, input logic [16:0] w);
      ch_data[k*17 +: 17] = w;
   endtask

   task automatic push4(input logic [7:0] b0, b1, b2, b3);
      exp_q.push_back(b0); exp_q.push_back(b1);
      exp_q.push_back(b2); exp_q.push_back(b3);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      ch_valid = '0;
      repeat (15) @(negedge clk_25MHz);
      exp_q.delete();
      start_cnt = 0;
      rst_n = 1'b1;
      @(negedge clk_25MHz);
   endtask

   task automatic wait_idle(input string nm, input int budget);
      int c = 0;
      while ((busy || exp_q.size() != 0 || !tx_ready) && c < budget) begin
         @(negedge clk_25MHz);
         c++;
      end
      chk({nm, "_done_in_budget"}, 32'(c < budget), 32'd1);
      chk({nm, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int k, c, bad_d, bad_s, gap;

      // reset state, checked before any clock edge
      #5;
      chk("rst_ch_ready", 32'(ch_ready), 32'h7);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_tx_start", 32'(tx_start), 32'h0);
      chk("rst_tx_data", 32'(tx_data), 32'h0);
      do_reset();

      // T1: single word on ch0, latency and byte order
      push4(8'h81, 8'h23, 8'h45, 8'hE7);
      set_ch(0, 17'h12345);
      ch_valid = 3'b001;
      @(negedge clk_25MHz);
      ch_valid = '0;
      chk("t1_lat_capture_start", 32'(tx_start), 32'h0);
      chk("t1_ready_after_capture", 32'(ch_ready), 32'h6);
      @(negedge clk_25MHz);
      chk("t1_lat_grant_start", 32'(tx_start), 32'h0);
      chk("t1_load_data", 32'(tx_data), 32'h81);
      chk("t1_ready_after_grant", 32'(ch_ready), 32'h7);
      @(negedge clk_25MHz);
      chk("t1_lat_start", 32'(tx_start), 32'h1);
      wait_idle("t1", 1000);
      repeat (5) @(negedge clk_25MHz);
      chk("t1_start_count", 32'(start_cnt), 32'd4);

      // T2: all three channels at once, grant order 0,1,2
      do_reset();
      push4(8'h80, 8'h00, 8'h01, 8'h81);
      push4(8'hA0, 8'h00, 8'h02, 8'hA2);
      push4(8'hC0, 8'h00, 8'h03, 8'hC3);
      set_ch(0, 17'h00001); set_ch(1, 17'h00002); set_ch(2, 17'h00003);
      ch_valid = 3'b111;
      @(negedge clk_25MHz);
      ch_valid = '0;
      chk("t2_ready_all_low", 32'(ch_ready), 32'h0);
      @(negedge clk_25MHz);
      chk("t2_ready_ch0_back", 32'(ch_ready), 32'h1);
      wait_idle("t2", 3000);
      chk("t2_start_count", 32'(start_cnt), 32'd12);

      // T3: ch1 streaming, ch2 one word interleaved after first ch1 frame
      do_reset();
      push4(8'hA0, 8'h01, 8'h00, 8'hA1);
      push4(8'hC0, 8'h02, 8'h00, 8'hC2);
      push4(8'hA0, 8'h01, 8'h01, 8'hA0);
      push4(8'hA0, 8'h01, 8'h02, 8'hA3);
      set_ch(2, 17'h00200);
      ch_valid[2] = 1'b1;
      for (int n = 0; n < 3; n++) begin
         set_ch(1, 17'(17'h00100 + n));
         ch_valid[1] = 1'b1;
         c = 0;
         while (!ch_ready[1] && c < 1000) begin
            @(negedge clk_25MHz);
            c++;
         end
         chk("t3_ch1_accept_in_budget", 32'(c < 1000), 32'd1);
         @(negedge clk_25MHz);
         ch_valid[2] = 1'b0;
      end
      ch_valid[1] = 1'b0;
      wait_idle("t3", 3000);
      chk("t3_start_count", 32'(start_cnt), 32'd16);

      // T4: UART stalls 200 cycles with arbiter in LOAD of byte1
      do_reset();
      push4(8'h81, 8'h23, 8'h45, 8'hE7);
      stall_next = 1'b1;
      set_ch(0, 17'h12345);
      ch_valid = 3'b001;
      @(negedge clk_25MHz);
      ch_valid = '0;
      c = 0;
      while (!stall_active && c < 500) begin
         @(negedge clk_25MHz);
         c++;
      end
      chk("t4_stall_reached", 32'(c < 500), 32'd1);
      bad_d = 0; bad_s = 0;
      for (int i = 0; i < 190; i++) begin
         if (tx_data !== 8'h23) bad_d++;
         if (tx_start !== 1'b0) bad_s++;
         @(negedge clk_25MHz);
      end
      chk("t4_data_held_bad_cycles", 32'(bad_d), 32'd0);
      chk("t4_start_quiet_bad_cycles", 32'(bad_s), 32'd0);
      wait_idle("t4", 1000);
      chk("t4_start_count", 32'(start_cnt), 32'd4);

      // T5: reset during byte2 start; buffered ch1 word must be discarded
      do_reset();
      push4(8'h81, 8'h23, 8'h45, 8'hE7);
      set_ch(0, 17'h12345); set_ch(1, 17'h0AAAA);
      ch_valid = 3'b011;
      @(negedge clk_25MHz);
      ch_valid = '0;
      k = 0; c = 0;
      while (k < 3 && c < 1000) begin
         @(negedge clk_25MHz);
         c++;
         if (tx_start) k++;
      end
      chk("t5_byte2_reached", 32'(k), 32'd3);
      #1 rst_n = 1'b0;
      exp_q.delete();
      #1;
      chk("t5_async_tx_start", 32'(tx_start), 32'h0);
      chk("t5_async_busy", 32'(busy), 32'h0);
      chk("t5_async_ch_ready", 32'(ch_ready), 32'h7);
      do_reset();
      c = 0;
      while (!tx_ready && c < 100) begin
         @(negedge clk_25MHz);
         c++;
      end
      push4(8'h81, 8'h23, 8'h45, 8'hE7);
      set_ch(0, 17'h12345);
      ch_valid = 3'b001;
      @(negedge clk_25MHz);
      ch_valid = '0;
      wait_idle("t5", 1000);
      repeat (40) @(negedge clk_25MHz);
      chk("t5_start_count", 32'(start_cnt), 32'd4);

      // T6: back-to-back frames honour the 16-cycle gap
      do_reset();
      push4(8'h80, 8'h00, 8'h01, 8'h81);
      push4(8'hA0, 8'h00, 8'h02, 8'hA2);
      set_ch(0, 17'h00001); set_ch(1, 17'h00002);
      ch_valid = 3'b011;
      @(negedge clk_25MHz);
      ch_valid = '0;
      k = 0; c = 0;
      while (k < 4 && c < 1000) begin
         @(negedge clk_25MHz);
         c++;
         if (tx_start) k++;
      end
      while (tx_ready && c < 1000) begin @(negedge clk_25MHz); c++; end
      while (!tx_ready && c < 1000) begin @(negedge clk_25MHz); c++; end
      gap = 0;
      while (!tx_start && c < 1000) begin
         @(negedge clk_25MHz);
         c++;
         gap++;
      end
      chk("t6_reached_second_frame", 32'(c < 1000), 32'd1);
      chk("t6_gap_at_least_16", 32'(gap >= 16), 32'd1);
      wait_idle("t6", 1000);
      chk("t6_start_count", 32'(start_cnt), 32'd8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
